// File: rtl/prod_sum_sched_pkg.sv
// Shared sizing helpers for the sum-of-products scheduler and its arbiter.
//   calc_id_w  : requester ID width for a given requester count
//   calc_lat   : datapath latency derived from its stage count
//   slice_lsb  : lsb of requester r's operand slice in a packed operand bus
package prod_sum_sched_pkg;

  // ID width; a single requester still gets one bit so vectors stay legal.
  function automatic int unsigned calc_id_w(input int unsigned n);
    return (n < 2) ? 1 : int'($clog2(n));
  endfunction

  // Result latency of a NUM_STAGES datapath: inputs register once per stage boundary.
  function automatic int unsigned calc_lat(input int unsigned stages);
    return stages - 1;
  endfunction

  // Requester r occupies elems*width bits starting at r*elems*width.
  function automatic int unsigned slice_lsb(input int unsigned r,
                                            input int unsigned elems,
                                            input int unsigned width);
    return r * elems * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter.
//   i_en       : permit a grant this cycle (0 forces an all-zero grant)
//   i_advance  : commit the grant, moving the pointer past the grantee
//   i_req      : request vector
//   o_gnt_c    : one-hot grant (combinational)
//   o_idx_c    : grant index (combinational)
//   o_any_c    : some request was granted (combinational)
module rr_arbiter
  import prod_sum_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_advance,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt_c,
  output logic [ID_W-1:0]    o_idx_c,
  output logic               o_any_c
);

  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_cand;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;

  // Search ptr, ptr+1, ... mod NUM_REQ; first hit wins.
  always_comb begin
    w_gnt  = '0;
    w_idx  = '0;
    w_any  = 1'b0;
    w_cand = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = ID_W'((32'(r_ptr) + k) % NUM_REQ);
      if (i_en && !w_any && i_req[w_cand]) begin
        w_any         = 1'b1;
        w_idx         = w_cand;
        w_gnt[w_cand] = 1'b1;
      end
    end
  end

  // Pointer moves one past the grantee; idle or blocked cycles leave it put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && w_any) begin
      r_ptr <= (32'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + ID_W'(1);
    end
  end

  assign o_gnt_c = w_gnt;
  assign o_idx_c = w_idx;
  assign o_any_c = w_any;

endmodule

// File: rtl/prod_sum_sched.sv
// Round-robin scheduler sharing one stallable pipelined sum-of-products
// datapath between NUM_REQ requesters.
//   req_valid/req_ready/req_tc/req_a/req_b : per-requester operand handshake
//   dp_en/dp_tc/dp_a/dp_b/dp_sum           : datapath control, operands, result
//   out_valid/out_ready/out_id/out_sum     : result handshake with owner ID
//   flush                                  : invalidate everything in flight
module prod_sum_sched
  import prod_sum_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned A_WIDTH    = 8,
  parameter int unsigned B_WIDTH    = 8,
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned SUM_WIDTH  = 18,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned ID_W       = calc_id_w(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0]                    req_tc,
  input  logic [NUM_REQ*NUM_INPUTS*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*NUM_INPUTS*B_WIDTH-1:0] req_b,
  output logic                                  dp_en,
  output logic                                  dp_tc,
  output logic [NUM_INPUTS*A_WIDTH-1:0]         dp_a,
  output logic [NUM_INPUTS*B_WIDTH-1:0]         dp_b,
  input  logic [SUM_WIDTH-1:0]                  dp_sum,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ID_W-1:0]                       out_id,
  output logic [SUM_WIDTH-1:0]                  out_sum
);

  localparam int unsigned LAT  = calc_lat(NUM_STAGES);
  localparam int unsigned A_VW = NUM_INPUTS * A_WIDTH;
  localparam int unsigned B_VW = NUM_INPUTS * B_WIDTH;

  logic [LAT-1:0]           r_vld;
  logic [LAT-1:0][ID_W-1:0] r_id;

  logic               w_stall;
  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic [A_VW-1:0]    w_a_vec [NUM_REQ];
  logic [B_VW-1:0]    w_b_vec [NUM_REQ];

  // Unclaimed result at the tail blocks everything; a flush overrides it.
  assign w_stall  = r_vld[LAT-1] & ~out_ready & ~flush;
  assign dp_en    = ~w_stall;
  // Reset gating keeps req_ready low while rst_n is held.
  assign w_arb_en = rst_n & ~w_stall & ~flush;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_arb_en),
    .i_advance (dp_en),
    .i_req     (req_valid),
    .o_gnt_c   (w_gnt),
    .o_idx_c   (w_idx),
    .o_any_c   (w_any)
  );

  assign req_ready = w_gnt;

  // Per-requester operand slices.
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_slice
    assign w_a_vec[r] = req_a[slice_lsb(r, NUM_INPUTS, A_WIDTH) +: A_VW];
    assign w_b_vec[r] = req_b[slice_lsb(r, NUM_INPUTS, B_WIDTH) +: B_VW];
  end

  // Operand isolation: an idle slot feeds zeros into the datapath.
  assign dp_a  = w_any ? w_a_vec[w_idx] : '0;
  assign dp_b  = w_any ? w_b_vec[w_idx] : '0;
  assign dp_tc = w_any & req_tc[w_idx];

  // Valid/ID shadow of the datapath pipeline; id holds through a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_id  <= '0;
    end else if (flush) begin
      r_vld <= '0;
    end else if (!w_stall) begin
      r_vld[0] <= w_any;
      r_id[0]  <= w_idx;
      for (int unsigned k = 1; k < LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_id[k]  <= r_id[k-1];
      end
    end
  end

  assign out_valid = r_vld[LAT-1];
  assign out_id    = r_id[LAT-1];
  assign out_sum   = dp_sum;

endmodule

// File: tb/tb_prod_sum_sched.sv
// Directed bench for prod_sum_sched with a behavioural 3-stage
// sum-of-products datapath (stalls on en=0, clears on reset).
module tb_prod_sum_sched;

  localparam int unsigned NR = 4;
  localparam int unsigned NI = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned BW = 8;
  localparam int unsigned SW = 18;
  localparam int unsigned IW = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0]        req_tc;
  logic [NR*NI*AW-1:0]  req_a;
  logic [NR*NI*BW-1:0]  req_b;
  logic                 dp_en;
  logic                 dp_tc;
  logic [NI*AW-1:0]     dp_a;
  logic [NI*BW-1:0]     dp_b;
  logic [SW-1:0]        dp_sum;
  logic                 out_valid;
  logic                 out_ready;
  logic [IW-1:0]        out_id;
  logic [SW-1:0]        out_sum;

  int n_checks = 0;
  int n_errors = 0;

  prod_sum_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tc    (req_tc),
    .req_a     (req_a),
    .req_b     (req_b),
    .dp_en     (dp_en),
    .dp_tc     (dp_tc),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_sum    (dp_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_sum   (out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: stage 1 registers operands, stage 2 the sum.
  logic [NI*AW-1:0] s1_a;
  logic [NI*BW-1:0] s1_b;
  logic             s1_tc;
  logic [SW-1:0]    s2_sum;

  function automatic logic [SW-1:0] sop(input logic [NI*AW-1:0] a,
                                        input logic [NI*BW-1:0] b,
                                        input logic tc);
    logic [SW-1:0] acc;
    logic [SW-1:0] ea;
    logic [SW-1:0] eb;
    acc = '0;
    for (int i = 0; i < NI; i++) begin
      ea = {{(SW-AW){tc & a[i*AW+AW-1]}}, a[i*AW +: AW]};
      eb = {{(SW-BW){tc & b[i*BW+BW-1]}}, b[i*BW +: BW]};
      acc = acc + SW'(ea * eb);
    end
    return acc;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_tc  <= 1'b0;
      s2_sum <= '0;
    end else if (dp_en) begin
      s1_a   <= dp_a;
      s1_b   <= dp_b;
      s1_tc  <= dp_tc;
      s2_sum <= sop(s1_a, s1_b, s1_tc);
    end
  end
  assign dp_sum = s2_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic tc,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] b0, input logic [7:0] b1);
    req_tc[r]           = tc;
    req_a[r*NI*AW +: 16] = {a1, a0};
    req_b[r*NI*BW +: 16] = {b1, b0};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_tc    = '0;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;

    // Reset state, with requests present to prove gating.
    set_op(0, 1'b0, 8'd3, 8'd2, 8'd4, 8'd5);
    req_valid = 4'b1111;
    tick();
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_dp_en", 32'(dp_en), 32'h1);
    check("rst_dp_a", 32'(dp_a), 32'h0);
    check("rst_dp_tc", 32'(dp_tc), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_id", 32'(out_id), 32'h0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Req0 unsigned: 3*4 + 2*5 = 22.
    req_valid = 4'b0001;
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    check("t1_dp_a", 32'(dp_a), 32'h0203);
    check("t1_dp_b", 32'(dp_b), 32'h0504);
    tick();
    req_valid = '0;
    #1;
    check("t1_ready_off", 32'(req_ready), 32'h0);
    check("t1_lat1_valid", 32'(out_valid), 32'h0);
    tick();
    #1;
    check("t1_out_valid", 32'(out_valid), 32'h1);
    check("t1_out_id", 32'(out_id), 32'h0);
    check("t1_out_sum", 32'(out_sum), 32'd22);
    tick();
    #1;
    check("t1_out_done", 32'(out_valid), 32'h0);

    // Req2 signed: -3*4 + 2*-1 = -14.
    set_op(2, 1'b1, 8'hFD, 8'h02, 8'h04, 8'hFF);
    req_valid = 4'b0100;
    #1;
    check("t2_ready", 32'(req_ready), 32'h4);
    check("t2_dp_tc", 32'(dp_tc), 32'h1);
    tick();
    req_valid = '0;
    tick();
    #1;
    check("t2_out_valid", 32'(out_valid), 32'h1);
    check("t2_out_id", 32'(out_id), 32'h2);
    check("t2_out_sum", 32'(out_sum), 32'h3FFF2);
    tick();

    // Full-rate round robin from ptr 0, with a 3-cycle back-pressure window.
    do_reset();
    for (int r = 0; r < 4; r++) set_op(r, 1'b0, 8'(r + 1), 8'd1, 8'd1, 8'd1);
    req_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          check("st_dp_en", 32'(dp_en), 32'h0);
          check("st_ready", 32'(req_ready), 32'h0);
          check("st_valid", 32'(out_valid), 32'h1);
          check("st_id", 32'(out_id), 32'h2);
          check("st_sum", 32'(out_sum), 32'd4);
          tick();
        end
        out_ready = 1'b1;
      end
      #1;
      check("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
      if (i >= 2) begin
        check("rr_valid", 32'(out_valid), 32'h1);
        check("rr_id", 32'(out_id), 32'((i - 2) % 4));
        check("rr_sum", 32'(out_sum), 32'(((i - 2) % 4) + 2));
      end else begin
        check("rr_fill", 32'(out_valid), 32'h0);
      end
      tick();
    end
    req_valid = '0;
    #1;
    check("rr_tail_id", 32'(out_id), 32'h2);
    check("rr_tail_sum", 32'(out_sum), 32'd4);
    tick();
    #1;
    check("rr_tail2_id", 32'(out_id), 32'h3);
    check("rr_tail2_sum", 32'(out_sum), 32'd5);
    tick();
    #1;
    check("rr_drained", 32'(out_valid), 32'h0);

    // Flush with two in flight (ptr ends at 3 after granting req2).
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0100;
    tick();
    flush     = 1'b1;
    req_valid = 4'b0010;
    #1;
    check("fl_ready", 32'(req_ready), 32'h0);
    check("fl_dp_en", 32'(dp_en), 32'h1);
    check("fl_dp_a", 32'(dp_a), 32'h0);
    tick();
    flush     = 1'b0;
    req_valid = '0;
    #1;
    check("fl_valid", 32'(out_valid), 32'h0);
    tick();
    #1;
    check("fl_valid2", 32'(out_valid), 32'h0);
    req_valid = 4'b1111;
    #1;
    check("fl_ptr", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    tick();
    tick();

    // Flush clears a stall.
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    out_ready = 1'b0;
    tick();
    #1;
    check("fs_stalled", 32'(dp_en), 32'h0);
    flush = 1'b1;
    #1;
    check("fs_dp_en", 32'(dp_en), 32'h1);
    tick();
    flush = 1'b0;
    #1;
    check("fs_valid", 32'(out_valid), 32'h0);
    check("fs_unstall", 32'(dp_en), 32'h1);
    out_ready = 1'b1;
    tick();

    // Asynchronous reset mid-stream.
    req_valid = 4'b1111;
    tick();
    tick();
    #1;
    check("mr_pre_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(out_valid), 32'h0);
    check("mr_id", 32'(out_id), 32'h0);
    check("mr_ready", 32'(req_ready), 32'h0);
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b0110;
    #1;
    check("mr_first", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    #1;
    check("mr_out_id", 32'(out_id), 32'h1);
    check("mr_out_sum", 32'(out_sum), 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
